// File: rtl/cs2fifoc.sv
// Packet framer: header, nine snapshotted payload bytes, zero pad and 8-bit checksum into a TX FIFO.
// First write two cycles after fs is seen in IDLE; writes stall (counter and checksum hold) while fifoc_full.
module cs2fifoc #(
   parameter logic [15:0] HEAD    = 16'h55AA,
   parameter logic [11:0] MAX_LEN = 12'd32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fs,
   output logic        fd,
   input  logic [11:0] data_len,
   input  logic [7:0]  kind_dev,
   input  logic [7:0]  info_sr,
   input  logic [7:0]  cmd_filt,
   input  logic [7:0]  cmd_mix0,
   input  logic [7:0]  cmd_reg4,
   input  logic [7:0]  cmd_reg5,
   input  logic [7:0]  cmd_reg6,
   input  logic [7:0]  cmd_reg7,
   input  logic [7:0]  cmd_mix1,
   input  logic        fifoc_full,
   output logic        fifoc_txen,
   output logic [7:0]  fifoc_txd,
   output logic        err,
   output logic [7:0]  so
);

   typedef enum logic [7:0] {
      IDLE = 8'h00,
      PREP = 8'h01,
      WORK = 8'h03,
      LAST = 8'h0F
   } state_t;

   state_t      state;
   logic [11:0] len_q;
   logic [11:0] cnt;
   logic [7:0]  csum;
   logic [7:0]  pay_q [9];
   logic [7:0]  byte_d;
   logic        len_ok;
   logic        last_byte;

   assign len_ok     = (data_len >= 12'd12) && (data_len <= MAX_LEN);
   assign last_byte  = (cnt == len_q - 12'd1);
   assign fifoc_txen = (state == WORK) && !fifoc_full;
   assign fifoc_txd  = (state == WORK) ? byte_d : 8'h00;
   assign fd         = (state == LAST);
   assign so         = state;

   // Legal lengths are >= 12, so the checksum slot never overlaps header or payload.
   always_comb begin
      byte_d = 8'h00;
      if (last_byte) begin
         byte_d = csum;
      end else if (cnt <= 12'd10) begin
         case (cnt[3:0])
            4'd0:    byte_d = HEAD[15:8];
            4'd1:    byte_d = HEAD[7:0];
            4'd2:    byte_d = pay_q[0];
            4'd3:    byte_d = pay_q[1];
            4'd4:    byte_d = pay_q[2];
            4'd5:    byte_d = pay_q[3];
            4'd6:    byte_d = pay_q[4];
            4'd7:    byte_d = pay_q[5];
            4'd8:    byte_d = pay_q[6];
            4'd9:    byte_d = pay_q[7];
            4'd10:   byte_d = pay_q[8];
            default: byte_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         len_q <= '0;
         cnt   <= '0;
         csum  <= '0;
         err   <= 1'b0;
         for (int k = 0; k < 9; k++) pay_q[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fs) state <= PREP;
            end
            PREP: begin
               len_q    <= data_len;
               pay_q[0] <= kind_dev;
               pay_q[1] <= info_sr;
               pay_q[2] <= cmd_filt;
               pay_q[3] <= cmd_mix0;
               pay_q[4] <= cmd_reg4;
               pay_q[5] <= cmd_reg5;
               pay_q[6] <= cmd_reg6;
               pay_q[7] <= cmd_reg7;
               pay_q[8] <= cmd_mix1;
               cnt      <= '0;
               csum     <= '0;
               err      <= !len_ok;
               state    <= len_ok ? WORK : LAST;
            end
            WORK: begin
               if (fifoc_txen) begin
                  if (last_byte) begin
                     state <= LAST;
                  end else begin
                     cnt <= cnt + 12'd1;
                     if (cnt >= 12'd2) csum <= csum + byte_d;
                  end
               end
            end
            LAST: begin
               if (!fs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cs2fifoc.sv
// Randomized bench for cs2fifoc: a queue-based packet model is compared with the bytes captured from the FIFO port.
module tb_cs2fifoc;

   logic        clk = 1'b0;
   logic        rst;
   logic        fs;
   logic        fd;
   logic [11:0] data_len;
   logic [7:0]  pay [9];
   logic        fifoc_full;
   logic        fifoc_txen;
   logic [7:0]  fifoc_txd;
   logic        err;
   logic [7:0]  so;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_wr;
   logic [7:0] got [$];
   logic [7:0] exp_q [$];

   cs2fifoc dut (
      .clk(clk), .rst(rst), .fs(fs), .fd(fd), .data_len(data_len),
      .kind_dev(pay[0]), .info_sr(pay[1]), .cmd_filt(pay[2]), .cmd_mix0(pay[3]),
      .cmd_reg4(pay[4]), .cmd_reg5(pay[5]), .cmd_reg6(pay[6]), .cmd_reg7(pay[7]),
      .cmd_mix1(pay[8]), .fifoc_full(fifoc_full), .fifoc_txen(fifoc_txen),
      .fifoc_txd(fifoc_txd), .err(err), .so(so)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // FIFO-side monitor: capture every accepted byte and police writes into a full FIFO.
   always @(negedge clk) begin
      if (fifoc_txen) begin
         if (got.size() == 0) first_wr = cyc;
         got.push_back(fifoc_txd);
      end
      if (fifoc_full) chk("no_txen_while_full", 32'(fifoc_txen), 32'd0);
   end

   task automatic set_pay_seq(input logic [7:0] base);
      for (int k = 0; k < 9; k++) pay[k] = base + 8'(k);
   endtask

   task automatic set_pay_rand();
      for (int k = 0; k < 9; k++) pay[k] = 8'($urandom);
   endtask

   // mode 0: never full, 1: random full, 2: full for 3 cycles after byte 4.
   // Entered and left just after a rising edge.
   task automatic run_pkt(input int len, input int mode, input bit drop_fs, input string tag);
      int  c0, stall_left, sum, exp_fd;
      bit  legal, seen;
      legal = (len >= 12) && (len <= 32);
      exp_q.delete();
      got.delete();
      if (legal) begin
         exp_q.push_back(8'h55);
         exp_q.push_back(8'hAA);
         for (int k = 0; k < 9; k++) exp_q.push_back(pay[k]);
         while (exp_q.size() < len - 1) exp_q.push_back(8'h00);
         sum = 0;
         for (int k = 2; k < len - 1; k++) sum += int'(exp_q[k]);
         exp_q.push_back(8'(sum % 256));
      end
      data_len   = 12'(len);
      fs         = 1'b1;
      c0         = cyc;
      stall_left = 3;
      seen       = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (fd) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (n == 1) begin
            // snapshot already taken; these must not leak into the packet
            data_len = 12'($urandom);
            set_pay_rand();
         end
         if (drop_fs && n == 2) fs = 1'b0;
         case (mode)
            1:       fifoc_full = ($urandom_range(0, 2) == 0);
            2: begin
               if (got.size() >= 5 && stall_left > 0) begin
                  fifoc_full = 1'b1;
                  stall_left--;
               end else begin
                  fifoc_full = 1'b0;
               end
            end
            default: fifoc_full = 1'b0;
         endcase
      end
      chk({tag, " fd_seen"}, 32'(seen), 32'd1);
      if (mode != 1) begin
         exp_fd = legal ? c0 + len + 2 + ((mode == 2) ? 3 : 0) : c0 + 2;
         chk({tag, " fd_cycle"}, 32'(cyc), 32'(exp_fd));
      end
      if (legal && mode == 0) chk({tag, " first_write_cycle"}, 32'(first_wr), 32'(c0 + 2));
      chk({tag, " err"}, 32'(err), 32'(!legal));
      chk({tag, " so_last"}, 32'(so), 32'h0F);
      chk({tag, " byte_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      if (!drop_fs) begin
         repeat (3) @(negedge clk);
         chk({tag, " fd_held"}, 32'(fd), 32'd1);
         chk({tag, " no_writes_in_last"}, 32'(got.size()), 32'(exp_q.size()));
      end
      @(posedge clk);
      #1;
      fs         = 1'b0;
      fifoc_full = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " so_idle"}, 32'(so), 32'h00);
      chk({tag, " fd_low"}, 32'(fd), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int len;
      rst        = 1'b0;
      fs         = 1'b0;
      fifoc_full = 1'b0;
      data_len   = '0;
      set_pay_seq(8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst fd", 32'(fd), 32'd0);
      chk("rst txen", 32'(fifoc_txen), 32'd0);
      chk("rst txd", 32'(fifoc_txd), 32'h00);
      chk("rst so", 32'(so), 32'h00);
      chk("rst err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst so", 32'(so), 32'h00);
      chk("post_rst txen", 32'(fifoc_txen), 32'd0);
      @(posedge clk);
      #1;

      set_pay_seq(8'h01);
      run_pkt(12, 0, 1'b0, "len12");
      set_pay_seq(8'h01);
      run_pkt(16, 0, 1'b0, "len16");
      for (int k = 0; k < 9; k++) pay[k] = 8'hFF;
      run_pkt(12, 0, 1'b0, "wrap_ff");
      set_pay_seq(8'h01);
      run_pkt(12, 2, 1'b0, "stall3");
      run_pkt(8, 0, 1'b0, "illegal8");
      run_pkt(33, 0, 1'b0, "illegal33");
      set_pay_seq(8'h01);
      run_pkt(12, 0, 1'b0, "legal_after_err");
      run_pkt(11, 0, 1'b0, "illegal11");
      set_pay_rand();
      run_pkt(32, 0, 1'b0, "len32");
      set_pay_rand();
      run_pkt(20, 0, 1'b1, "fs_drop");

      for (int r = 0; r < 8; r++) begin
         set_pay_rand();
         len = (r % 4 == 3) ? int'($urandom_range(0, 4095)) : int'($urandom_range(12, 32));
         run_pkt(len, 1, 1'b0, $sformatf("rand%0d", r));
      end

      // Abort mid-packet, entered with err set by an illegal request.
      run_pkt(0, 0, 1'b0, "illegal0");
      set_pay_seq(8'h01);
      data_len = 12'd12;
      fs       = 1'b1;
      got.delete();
      n = 0;
      while (got.size() < 6 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("abort reached_byte5", 32'(got.size() >= 6), 32'd1);
      rst = 1'b0;
      fs  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort txen", 32'(fifoc_txen), 32'd0);
      chk("abort so", 32'(so), 32'h00);
      chk("abort err", 32'(err), 32'd0);
      chk("abort fd", 32'(fd), 32'd0);
      chk("abort txd", 32'(fifoc_txd), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("release so", 32'(so), 32'h00);
      chk("release txen", 32'(fifoc_txen), 32'd0);
      @(posedge clk);
      #1;
      set_pay_seq(8'h01);
      run_pkt(12, 0, 1'b0, "after_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cs2fifoc.md
CS2FIFOC -- requirements
Module: cs2fifoc

Interface
REQ-001 Parameter HEAD, 16'h55AA, two-byte packet header emitted first, high byte first.
REQ-002 Parameter MAX_LEN, 12'd32, largest legal packet length in bytes.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 fs  input  1  frame start request; level-held by controller until fd seen.
REQ-006 fd  output  1  frame done; high exactly while state is LAST.
REQ-007 data_len  input  12  total packet length in bytes, header and checksum included.
REQ-008 kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1  input  8 each  payload bytes, in this emission order.
REQ-009 fifoc_full  input  1  downstream TX FIFO full; no write permitted while high.
REQ-010 fifoc_txen  output  1  FIFO write enable, one byte per asserted cycle.
REQ-011 fifoc_txd  output  8  FIFO write data, valid when fifoc_txen is high.
REQ-012 err  output  8->1  registered error flag: 1 = last request had illegal data_len.
REQ-013 so  output  8  current state code, for debug.

Function
REQ-014 States and codes: IDLE 8'h00, PREP 8'h01, WORK 8'h03, LAST 8'h0F; any other code goes to IDLE.
REQ-015 Transitions:
- IDLE->PREP when fs=1.
- PREP->WORK when data_len is legal, else PREP->LAST.
- WORK->LAST on the cycle byte index len-1 is written.
- LAST->IDLE when fs=0.
REQ-016 Legal data_len: 12 <= data_len <= MAX_LEN.
REQ-017 PREP actions:
- Snapshot data_len and all nine payload bytes into internal registers.
- Clear byte counter and checksum to 0.
- Later input changes have no effect until the next PREP.
REQ-018 fifoc_txen = (state==WORK) && !fifoc_full, combinational from registered state; fifoc_txd is also combinational.
REQ-019 Byte index i is the counter value; it increments only on cycles with fifoc_txen=1. While fifoc_full=1, the counter and checksum hold.
REQ-020 Byte content by index:
- i=0: HEAD[15:8].
- i=1: HEAD[7:0].
- i=2..10: payload bytes in REQ-008 order.
- i=11..len-2: 8'h00.
- i=len-1: checksum.
REQ-021 Checksum = 8-bit wrap-around sum of bytes at indices 2..len-2; it accumulates on written bytes only.
REQ-022 Counter is 12 bits wide and never exceeds len-1.
REQ-023 err is set to 1 in PREP on illegal data_len and cleared to 0 in PREP on legal data_len; otherwise it holds. With illegal length, zero bytes are written.
REQ-024 fs falling during PREP or WORK is ignored; the packet always completes.
REQ-025 fs held high in LAST keeps fd=1 with no further writes; a new packet needs fs low, then high again.
REQ-026 Latency:
- fs high in IDLE at cycle N gives PREP at N+1.
- First write at N+2 if not full.
- fd rises one cycle after the last write.

Reset
REQ-027 rst=0 at a rising edge forces the following to 0: state=IDLE, counter, checksum, snapshot registers, err.
REQ-028 Reset values seen at outputs: fd=0, fifoc_txen=0, fifoc_txd=8'h00, so=8'h00.
REQ-029 Reset during WORK aborts the packet immediately, with no write on the cycle after the reset edge. Any partial packet already in the FIFO is not retracted.
REQ-030 Reset release has no effect on outputs until fs is sampled high in IDLE.

Verification
REQ-031 len=12, payload 01..09, never full -> 12 consecutive writes 55 AA 01 02 03 04 05 06 07 08 09 2D; fd high one cycle later; err=0.
REQ-032 len=16, same payload -> 55 AA 01..09 00 00 00 00 2D, 16 writes; checksum unchanged by the zero pads.
REQ-033 len=12, all payload FF -> last byte F7 (9*255 mod 256), checking checksum wrap.
REQ-034 len=12, fifoc_full high for 3 cycles after byte 4 -> no txen while full; byte stream identical to REQ-031; fd delayed by 3 cycles.
REQ-035 Illegal lengths:
- len=8 -> PREP->LAST, zero writes, err=1, fd high.
- len=33 -> same.
- Following len=12 request -> err returns to 0.
REQ-036 rst=0 asserted after byte 5 of a len=12 packet -> txen=0 from the next cycle, state IDLE, err=0. The next request sends a full, correct 12-byte packet.
